voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
Polyphony controller between the 14-key keypad input and the oscillator/mixer datapath that drives the PWM output. It scans synchronized key states one key per cycle and assigns pressed keys to a fixed pool of oscillator voices. It frees a voice when its key is released and emits start/stop strobes so each oscillator can reset phase and gate its envelope.

Parameters:
- NUM_KEYS, 14, number of keypad lines scanned.
- NUM_VOICES, 4, number of oscillator voices managed.
- KEY_W, 4, key index width; must satisfy 2**KEY_W >= NUM_KEYS.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- keypad_i  input  NUM_KEYS  raw key levels, 1 = pressed, asynchronous to clk
- voice_active_o  output  NUM_VOICES  1 = voice v currently owns a key
- voice_key_o  output  NUM_VOICES*KEY_W  key index per voice; voice v occupies bits [v*KEY_W +: KEY_W]
- voice_start_o  output  NUM_VOICES  one-cycle strobe when voice v takes a new key
- voice_stop_o  output  NUM_VOICES  one-cycle strobe when voice v is released
- dropped_o  output  1  one-cycle strobe when a press finds no free voice

Behaviour:
- Interface: one clock, clk; reset n_rst is asynchronous and active-low.
- Reset state: all outputs 0, voice table cleared, scan_idx = 0, synchronizer flops 0. Reset mid-operation aborts everything immediately, with no stop strobes.
- Input: 2-flop synchronizer per key producing key_s. Debounce is upstream and out of scope.
- Scan counter:
  - scan_idx increments every cycle, 0..NUM_KEYS-1, then wraps to 0.
  - One evaluation per cycle. At most one table update per cycle, so allocate and free never coincide.
- Evaluation of key k = scan_idx:
  - owned = some active voice has voice_key == k.
  - key_s[k]=1, not owned, free voice exists: allocate the lowest-index inactive voice v. Set active[v]=1, key[v]=k, start strobe for v.
  - key_s[k]=1, not owned, no free voice: dropped_o strobe. Re-evaluated on the next pass.
  - key_s[k]=0 and owned by v: active[v]=0, stop strobe for v. key[v] holds its last value.
  - Otherwise no action.
- Timing:
  - All outputs are registered.
  - voice_start_o[v] is high in the same cycle that voice_active_o[v]/voice_key_o first show the new owner. voice_stop_o[v] is high in the cycle active first reads 0.
  - Worst-case latency from a keypad_i edge to the table update: 2 sync cycles + NUM_KEYS scan cycles + 1.
- A key can never own two voices. A key held continuously generates exactly one start strobe.

Optional Feature:
- Macro VOICE_STEAL_EN.
- Defined:
  - Each voice keeps an age rank of $clog2(NUM_VOICES) bits.
  - On allocation, every other active voice's age increments, saturating at NUM_VOICES-1, and the new voice's age is set to 0.
  - A press with no free voice steals the oldest voice (highest age; ties go to the lowest index). That voice gets the new key, age 0, and voice_start_o only (no voice_stop_o).
  - dropped_o is tied 0.
- Undefined: no age logic; behaviour as above.

Decomposition:
- Package audio_synth_pkg: NUM_KEYS, NUM_VOICES and KEY_W constants; key_idx_t (KEY_W bits); voice_mask_t (NUM_VOICES bits).
- One combinational sub-module, voice_select:
  - Inputs: active mask and, when VOICE_STEAL_EN is defined, ages.
  - Outputs: lowest free voice index, free-exists flag, and oldest-voice index.
- The top block holds the synchronizer, scan counter, table and strobes.

Test Plan:
- Reset, then press key 3 only → after ≤17 cycles voice_active_o=0001, voice 0 key=3, voice_start_o[0] high for exactly 1 cycle; no further strobes over 100 cycles.
- Press keys 0-4 simultaneously, steal disabled → voices 0-3 own keys 0-3, dropped_o pulses once per 14-cycle pass on key 4.
- Continue that test: release key 1 → voice_stop_o[1] single pulse; within the next pass key 4 is allocated to voice 1 with voice_start_o[1], and dropped_o stops.
- Press 7 then release 7 within 2 cycles (before its scan) → no strobes, table unchanged.
- Hold keys 2 and 9, assert n_rst mid-scan → all outputs 0 asynchronously. After release, voices 0 and 1 are re-allocated in scan order (key 2 → v0, key 9 → v1).
- VOICE_STEAL_EN: press keys 0,1,2,3 on successive passes, then press key 5 → voice 0 (oldest) gets key 5 with voice_start_o[0] only; dropped_o stays 0.

Source files
------------

// File: rtl/audio_synth_pkg.sv
// Shared constants and types for the keypad-to-voice polyphony path.
package audio_synth_pkg;
  localparam int NUM_KEYS   = 14;
  localparam int NUM_VOICES = 4;
  localparam int KEY_W      = 4;
  localparam int VIDX_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int AGE_W      = VIDX_W;

  typedef logic [KEY_W-1:0]      key_idx_t;
  typedef logic [NUM_VOICES-1:0] voice_mask_t;
  typedef logic [VIDX_W-1:0]     voice_idx_t;
  typedef logic [AGE_W-1:0]      age_t;
endpackage

// File: rtl/voice_select.sv
// Combinational voice picker: lowest free voice and, with VOICE_STEAL_EN, the oldest voice.
module voice_select
  import audio_synth_pkg::*;
(
  input  voice_mask_t active,
`ifdef VOICE_STEAL_EN
  input  age_t        ages [NUM_VOICES],
  output voice_idx_t  oldest_idx,
`endif
  output voice_idx_t  free_idx,
  output logic        free_vld
);

  always_comb begin
    free_idx = '0;
    free_vld = 1'b0;
    // Descending walk so the lowest inactive index is the last one written.
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!active[v]) begin
        free_idx = voice_idx_t'(v);
        free_vld = 1'b1;
      end
    end
  end

`ifdef VOICE_STEAL_EN
  age_t best_age;

  // Strict compare keeps the lowest index on equal ages.
  always_comb begin
    best_age   = ages[0];
    oldest_idx = '0;
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (ages[v] > best_age) begin
        best_age   = ages[v];
        oldest_idx = voice_idx_t'(v);
      end
    end
  end
`endif

endmodule

// File: rtl/voice_allocator.sv
// Polyphony controller: scans synchronized keys one per cycle and binds them to voices.
// Define VOICE_STEAL_EN to steal the oldest voice instead of dropping a press.
module voice_allocator #(
  parameter int NUM_KEYS   = audio_synth_pkg::NUM_KEYS,
  parameter int NUM_VOICES = audio_synth_pkg::NUM_VOICES,
  parameter int KEY_W      = audio_synth_pkg::KEY_W
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic [NUM_KEYS-1:0]         keypad_i,
  output logic [NUM_VOICES-1:0]       voice_active_o,
  output logic [NUM_VOICES*KEY_W-1:0] voice_key_o,
  output logic [NUM_VOICES-1:0]       voice_start_o,
  output logic [NUM_VOICES-1:0]       voice_stop_o,
  output logic                        dropped_o
);
  import audio_synth_pkg::*;

  logic [NUM_KEYS-1:0] key_meta_p0;
  logic [NUM_KEYS-1:0] key_s_p1;
  logic [KEY_W-1:0]    scan_idx;
  voice_mask_t         active_q;
  logic [KEY_W-1:0]    key_tab [NUM_VOICES];

  logic       key_on, owned, free_vld;
  logic       alloc_vld, drop_req, release_req;
  voice_idx_t owner_idx, free_idx, alloc_idx;

`ifdef VOICE_STEAL_EN
  localparam age_t AGE_MAX = age_t'(NUM_VOICES - 1);
  age_t       age_q [NUM_VOICES];
  voice_idx_t oldest_idx;
`endif

  voice_select u_select (
    .active     (active_q),
`ifdef VOICE_STEAL_EN
    .ages       (age_q),
    .oldest_idx (oldest_idx),
`endif
    .free_idx   (free_idx),
    .free_vld   (free_vld)
  );

  // Stage p1 -> evaluation: decide the single table action for key scan_idx.
  always_comb begin
    key_on    = key_s_p1[scan_idx];
    owned     = 1'b0;
    owner_idx = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (active_q[v] && key_tab[v] == scan_idx) begin
        owned     = 1'b1;
        owner_idx = voice_idx_t'(v);
      end
    end
    alloc_vld   = key_on && !owned && free_vld;
    alloc_idx   = free_idx;
    drop_req    = key_on && !owned && !free_vld;
`ifdef VOICE_STEAL_EN
    if (key_on && !owned && !free_vld) begin
      alloc_vld = 1'b1;
      alloc_idx = oldest_idx;
    end
    drop_req    = 1'b0;
`endif
    release_req = !key_on && owned;
  end

  // Stage p0/p1: two-flop synchronizer; then scan counter, voice table and strobes.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      key_meta_p0   <= '0;
      key_s_p1      <= '0;
      scan_idx      <= '0;
      active_q      <= '0;
      voice_start_o <= '0;
      voice_stop_o  <= '0;
      dropped_o     <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) key_tab[v] <= '0;
    end else begin
      key_meta_p0   <= keypad_i;
      key_s_p1      <= key_meta_p0;
      scan_idx      <= (scan_idx == KEY_W'(NUM_KEYS - 1)) ? '0 : scan_idx + KEY_W'(1);
      voice_start_o <= '0;
      voice_stop_o  <= '0;
      dropped_o     <= 1'b0;
      if (alloc_vld) begin
        active_q[alloc_idx]      <= 1'b1;
        key_tab[alloc_idx]       <= scan_idx;
        voice_start_o[alloc_idx] <= 1'b1;
      end else if (drop_req) begin
        dropped_o <= 1'b1;
      end else if (release_req) begin
        active_q[owner_idx]     <= 1'b0;
        voice_stop_o[owner_idx] <= 1'b1;
      end
    end
  end

`ifdef VOICE_STEAL_EN
  // The newly bound voice becomes youngest; other live voices age, saturating.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int v = 0; v < NUM_VOICES; v++) age_q[v] <= '0;
    end else if (alloc_vld) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (voice_idx_t'(v) == alloc_idx)
          age_q[v] <= '0;
        else if (active_q[v] && age_q[v] != AGE_MAX)
          age_q[v] <= age_q[v] + age_t'(1);
      end
    end
  end
`endif

  assign voice_active_o = active_q;

  always_comb begin
    voice_key_o = '0;
    for (int v = 0; v < NUM_VOICES; v++) voice_key_o[v*KEY_W +: KEY_W] = key_tab[v];
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: directed key patterns, expected strobe events queued.
module tb_voice_allocator;
  localparam int NK = 14;
  localparam int NV = 4;
  localparam int KW = 4;

  logic           clk = 1'b0;
  logic           n_rst = 1'b1;
  logic [NK-1:0]  keypad_i = '0;
  logic [NV-1:0]  voice_active_o;
  logic [NV*KW-1:0] voice_key_o;
  logic [NV-1:0]  voice_start_o;
  logic [NV-1:0]  voice_stop_o;
  logic           dropped_o;

  voice_allocator #(.NUM_KEYS(NK), .NUM_VOICES(NV), .KEY_W(KW)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .keypad_i       (keypad_i),
    .voice_active_o (voice_active_o),
    .voice_key_o    (voice_key_o),
    .voice_start_o  (voice_start_o),
    .voice_stop_o   (voice_stop_o),
    .dropped_o      (dropped_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  start;
    logic [3:0]  stop;
    logic        drop;
    logic [3:0]  act;
    logic [15:0] keys;
  } ev_t;

  ev_t exp_q[$];
  ev_t got_e, exp_e;
  int  n_chk = 0;
  int  n_fail = 0;
  int  post_cnt;

  // Counts active edges since reset so stimulus can be placed relative to the scan.
  always @(posedge clk or negedge n_rst)
    if (!n_rst) post_cnt <= 0;
    else        post_cnt <= post_cnt + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic push(input logic [3:0] st, input logic [3:0] sp, input logic dr,
                      input logic [3:0] ac, input logic [15:0] ks);
    exp_q.push_back(ev_t'({st, sp, dr, ac, ks}));
  endtask

  task automatic drain(input string nm, input int max);
    int c = 0;
    while (exp_q.size() != 0 && c < max) begin
      @(posedge clk); #3;
      c++;
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d events still pending after %0d cycles, expected 0",
               nm, exp_q.size(), max);
      exp_q.delete();
    end
  endtask

  task automatic wait_after_eval(input int k);
    int c = 0;
    do begin
      @(posedge clk); #1;
      c++;
    end while (((post_cnt - 1) % NK) != k && c < 40);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  // Monitor: every strobe cycle must match the next queued event exactly.
  always @(negedge clk) begin
    if (n_rst && ((|voice_start_o) || (|voice_stop_o) || dropped_o)) begin
      got_e = ev_t'({voice_start_o, voice_stop_o, dropped_o, voice_active_o, voice_key_o});
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got start=%b stop=%b drop=%b act=%b keys=%h, expected no event",
                 got_e.start, got_e.stop, got_e.drop, got_e.act, got_e.keys);
      end else begin
        exp_e = exp_q.pop_front();
        if (got_e !== exp_e) begin
          n_fail++;
          $display("FAIL event: got start=%b stop=%b drop=%b act=%b keys=%h, expected start=%b stop=%b drop=%b act=%b keys=%h",
                   got_e.start, got_e.stop, got_e.drop, got_e.act, got_e.keys,
                   exp_e.start, exp_e.stop, exp_e.drop, exp_e.act, exp_e.keys);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 n_rst = 1'b0;
    #10;
    check("rst_active", voice_active_o, 0);
    check("rst_keys",   voice_key_o,    0);
    check("rst_start",  voice_start_o,  0);
    check("rst_stop",   voice_stop_o,   0);
    check("rst_drop",   dropped_o,      0);
    @(negedge clk) n_rst = 1'b1;

    // Single key: one start, then silence while held.
    wait_after_eval(0);
    keypad_i[3] = 1'b1;
    push(4'b0001, 4'b0000, 1'b0, 4'b0001, 16'h0003);
    drain("t1_start_latency", 17);
    idle(100);
    check("t1_table_hold", {voice_active_o, voice_key_o}, {4'b0001, 16'h0003});
    keypad_i[3] = 1'b0;
    push(4'b0000, 4'b0001, 1'b0, 4'b0000, 16'h0003);
    drain("t1_release", 20);

    // Keys 2 and 9 held, then asynchronous reset and re-allocation in scan order.
    wait_after_eval(13);
    keypad_i[2] = 1'b1;
    keypad_i[9] = 1'b1;
    push(4'b0001, 4'b0000, 1'b0, 4'b0001, 16'h0002);
    push(4'b0010, 4'b0000, 1'b0, 4'b0011, 16'h0092);
    drain("t4_alloc", 30);
    idle(3);
    #4 n_rst = 1'b0;
    #1;
    check("t4_arst_active", voice_active_o, 0);
    check("t4_arst_keys",   voice_key_o,    0);
    check("t4_arst_start",  voice_start_o,  0);
    check("t4_arst_stop",   voice_stop_o,   0);
    check("t4_arst_drop",   dropped_o,      0);
    push(4'b0001, 4'b0000, 1'b0, 4'b0001, 16'h0002);
    push(4'b0010, 4'b0000, 1'b0, 4'b0011, 16'h0092);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    drain("t4_realloc", 30);
    keypad_i = '0;
    push(4'b0000, 4'b0001, 1'b0, 4'b0010, 16'h0092);
    push(4'b0000, 4'b0010, 1'b0, 4'b0000, 16'h0092);
    drain("t4_release", 30);

    // Short glitch on key 7 that is gone before its scan slot.
    wait_after_eval(8);
    keypad_i[7] = 1'b1;
    @(posedge clk); #1;
    keypad_i[7] = 1'b0;
    idle(30);
    check("t3_glitch_table", {voice_active_o, voice_key_o}, {4'b0000, 16'h0092});

`ifndef VOICE_STEAL_EN
    // Five keys on four voices: key 4 is dropped once per pass until a voice frees.
    wait_after_eval(11);
    keypad_i[4:0] = 5'b11111;
    push(4'b0001, 4'b0000, 1'b0, 4'b0001, 16'h0090);
    push(4'b0010, 4'b0000, 1'b0, 4'b0011, 16'h0010);
    push(4'b0100, 4'b0000, 1'b0, 4'b0111, 16'h0210);
    push(4'b1000, 4'b0000, 1'b0, 4'b1111, 16'h3210);
    push(4'b0000, 4'b0000, 1'b1, 4'b1111, 16'h3210);
    push(4'b0000, 4'b0000, 1'b1, 4'b1111, 16'h3210);
    drain("t2_fill_drop", 40);
    keypad_i[1] = 1'b0;
    push(4'b0000, 4'b0010, 1'b0, 4'b1101, 16'h3210);
    push(4'b0010, 4'b0000, 1'b0, 4'b1111, 16'h3240);
    drain("t2_reuse", 30);
    keypad_i = '0;
    push(4'b0000, 4'b0001, 1'b0, 4'b1110, 16'h3240);
    push(4'b0000, 4'b0100, 1'b0, 4'b1010, 16'h3240);
    push(4'b0000, 4'b1000, 1'b0, 4'b0010, 16'h3240);
    push(4'b0000, 4'b0010, 1'b0, 4'b0000, 16'h3240);
    drain("t2_release_all", 30);
`else
    // Keys 0..3 on successive passes, then key 5 steals the oldest voice (voice 0).
    wait_after_eval(11);
    keypad_i[0] = 1'b1;
    push(4'b0001, 4'b0000, 1'b0, 4'b0001, 16'h0090);
    drain("t5_key0", 30);
    keypad_i[1] = 1'b1;
    push(4'b0010, 4'b0000, 1'b0, 4'b0011, 16'h0010);
    drain("t5_key1", 30);
    keypad_i[2] = 1'b1;
    push(4'b0100, 4'b0000, 1'b0, 4'b0111, 16'h0210);
    drain("t5_key2", 30);
    keypad_i[3] = 1'b1;
    push(4'b1000, 4'b0000, 1'b0, 4'b1111, 16'h3210);
    drain("t5_key3", 30);
    keypad_i[5] = 1'b1;
    push(4'b0001, 4'b0000, 1'b0, 4'b1111, 16'h3215);
    drain("t5_steal", 30);
    keypad_i = '0;
    push(4'b0000, 4'b0010, 1'b0, 4'b1101, 16'h3215);
    push(4'b0000, 4'b0100, 1'b0, 4'b1001, 16'h3215);
    push(4'b0000, 4'b1000, 1'b0, 4'b0001, 16'h3215);
    push(4'b0000, 4'b0001, 1'b0, 4'b0000, 16'h3215);
    drain("t5_release_all", 30);
`endif

    idle(30);
    check("final_table_idle", voice_active_o, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
